crop_frame_sequencer: RTL and testbench
=======================================

Name: crop_frame_sequencer

Overview:
- Run-time controller for the streaming crop path: queues crop-origin requests and, for each IN_ROWS x IN_COLS input frame, applies one queued origin.
- Tracks the raster row/column of incoming pixels, forwards only pixels inside the OUT_ROWS x OUT_COLS window through a registered valid/ready output stage, and discards the rest.
- Sits between the pixel source and the downstream FIFO/consumer; replaces compile-time Y_1/X_1 with per-frame origins.

Parameters:
- PIXEL_BIT_WIDTH, 12, pixel word width
- IN_ROWS, 40, input frame rows
- IN_COLS, 40, input frame columns
- OUT_ROWS, 20, crop window rows
- OUT_COLS, 20, crop window columns
- REQ_DEPTH, 4, crop-request queue depth (power of 2, >=2)
- YW, $clog2(IN_ROWS), row index width (derived)
- XW, $clog2(IN_COLS), column index width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  crop request valid
- cfg_ready  out  1  request queue not full
- cfg_y  in  YW  window top row
- cfg_x  in  XW  window left column
- cfg_err  out  1  one-cycle pulse: request rejected (out of range)
- pixel_in  in  PIXEL_BIT_WIDTH  input pixel, raster order
- in_valid  in  1  input valid
- in_ready  out  1  input ready
- pixel_out  out  PIXEL_BIT_WIDTH  cropped pixel
- out_valid  out  1  output valid
- out_ready  in  1  output ready
- out_last  out  1  marks final pixel of current crop
- busy  out  1  high in STREAM state

Behaviour:
- Reset (reset=1 at posedge clk): queue emptied; state=IDLE; row/col counters=0; out_valid=0, out_last=0, pixel_out=0, cfg_err=0, busy=0. Reset mid-frame discards the partial frame and any undelivered output; the source must restart at pixel (0,0).
- Request queue:
  - cfg_ready = !full; a push occurs on cfg_valid & cfg_ready.
  - Valid iff cfg_y+OUT_ROWS <= IN_ROWS and cfg_x+OUT_COLS <= IN_COLS; invalid requests complete the handshake, are not enqueued, and cfg_err=1 on the next cycle.
  - A push and a pop in the same cycle are both honored.
  - cfg_ready is derived from registered full only, so it does not rise during a same-cycle pop.
- FSM:
  - IDLE: in_ready=0. If the queue is non-empty, pop the head into origin registers (y0, x0), clear counters, and go to STREAM next cycle. A request pushed into an empty queue reaches STREAM after 2 cycles.
  - STREAM: busy=1. A pixel is accepted on in_valid & in_ready, then col++. At col==IN_COLS-1, col wraps to 0 and row++. On acceptance of pixel (IN_ROWS-1, IN_COLS-1), go to IDLE.
- Window test: inwin = (row>=y0) & (row<y0+OUT_ROWS) & (col>=x0) & (col<x0+OUT_COLS). Comparisons use widths YW+1/XW+1 so they do not overflow.
- in_ready in STREAM: !inwin | !out_valid | out_ready. Out-of-window pixels are consumed at 1/cycle regardless of output backpressure.
- Output stage:
  - An accepted in-window pixel loads pixel_out and sets out_valid next cycle (latency 1).
  - out_last = 1 when loaded pixel is (y0+OUT_ROWS-1, x0+OUT_COLS-1).
  - out_valid clears on out_ready with no new load. Simultaneous drain+load keeps out_valid=1 with new data.
  - pixel_out/out_last are held stable while out_valid & !out_ready.
- Frame boundary: the FSM may return to IDLE and start the next frame while the last output is still pending. The output register is independent of FSM state.
- Exactly OUT_ROWS*OUT_COLS outputs per frame, one out_last per frame.

Optional Feature:
- Macro CROP_SEQ_STATS_EN.
- When defined, adds outputs frame_count[31:0] and drop_count[31:0], both reset to 0.
  - frame_count increments when the last pixel of a frame is accepted.
  - drop_count increments per accepted out-of-window pixel.
  - Both wrap at 2^32.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Push (10,10); stream 1600 index-valued pixels (value=index) with random in_valid/out_ready → 400 outputs with values 410..429, 450..469, …, 1170..1189; out_last only on value 1189.
- Push (0,0) then (20,20); stream two frames → frame 1 first output 0, last 779; frame 2 first output 820, last 1599; no gap errors.
- Push (21,5) → cfg_err pulses 1 cycle, queue stays empty, in_ready stays 0. Push (20,20) → accepted.
- Push 4 requests with no input traffic → cfg_ready=0 after the 4th. Fifth cfg_valid held until one frame completes; it is accepted the cycle after cfg_ready rises.
- Hold out_ready=0 during frame with origin (10,10) → pixel 410 held stable on pixel_out; input continues through pixels 0..409 and then stalls (in_ready=0) at pixel 411.
- Assert reset at pixel 800 mid-frame → out_valid=0 next cycle, state IDLE, queue empty. New request + full frame yields correct 400 outputs. With CROP_SEQ_STATS_EN: drop_count=1200, frame_count=1 after that frame.

Source files
------------

// File: rtl/crop_frame_sequencer.sv
// Per-frame crop controller: queues crop origins, tracks the raster position and forwards in-window pixels.
// Optional build macro CROP_SEQ_STATS_EN adds frame_count/drop_count statistics outputs.
module crop_frame_sequencer #(
  parameter int unsigned PIXEL_BIT_WIDTH = 12,
  parameter int unsigned IN_ROWS         = 40,
  parameter int unsigned IN_COLS         = 40,
  parameter int unsigned OUT_ROWS        = 20,
  parameter int unsigned OUT_COLS        = 20,
  parameter int unsigned REQ_DEPTH       = 4,
  parameter int unsigned YW              = $clog2(IN_ROWS),
  parameter int unsigned XW              = $clog2(IN_COLS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [YW-1:0]              cfg_y,
  input  logic [XW-1:0]              cfg_x,
  output logic                       cfg_err,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy
`ifdef CROP_SEQ_STATS_EN
  ,
  output logic [31:0]                frame_count,
  output logic [31:0]                drop_count
`endif
);

  localparam int unsigned AW = $clog2(REQ_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned YE = YW + 1;
  localparam int unsigned XE = XW + 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [YW-1:0] qy_q [REQ_DEPTH];
  logic [YW-1:0] qy_d [REQ_DEPTH];
  logic [XW-1:0] qx_q [REQ_DEPTH];
  logic [XW-1:0] qx_d [REQ_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          cfg_err_q, cfg_err_d;

  logic [0:0]    state_q, state_d;
  logic [YW-1:0] row_q, row_d, y0_q, y0_d;
  logic [XW-1:0] col_q, col_d, x0_q, x0_d;

  logic [PIXEL_BIT_WIDTH-1:0] pixel_out_q, pixel_out_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic          cfg_ok, cfg_fire, push, pop, empty;
  logic [YE-1:0] row_e, y0_e, y_hi;
  logic [XE-1:0] col_e, x0_e, x_hi;
  logic          inwin, win_last, accept, load, last_col, last_row;

  // Request legality and queue handshakes
  always_comb begin
    cfg_ok   = ((YE'(cfg_y) + YE'(OUT_ROWS)) <= YE'(IN_ROWS)) &&
               ((XE'(cfg_x) + XE'(OUT_COLS)) <= XE'(IN_COLS));
    cfg_fire = cfg_valid & ~full_q;
    push     = cfg_fire & cfg_ok;
    empty    = (count_q == CW'(0));
    pop      = (state_q == S_IDLE) & ~empty;
  end

  // Window test on widened indices so the upper bounds cannot wrap
  always_comb begin
    row_e    = YE'(row_q);
    y0_e     = YE'(y0_q);
    y_hi     = y0_e + YE'(OUT_ROWS);
    col_e    = XE'(col_q);
    x0_e     = XE'(x0_q);
    x_hi     = x0_e + XE'(OUT_COLS);
    inwin    = (row_e >= y0_e) && (row_e < y_hi) && (col_e >= x0_e) && (col_e < x_hi);
    win_last = (row_e == (y_hi - YE'(1))) && (col_e == (x_hi - XE'(1)));
    last_col = (col_q == XW'(IN_COLS - 1));
    last_row = (row_q == YW'(IN_ROWS - 1));
    in_ready = (state_q == S_STREAM) & (~inwin | ~out_valid_q | out_ready);
    accept   = in_valid & in_ready;
    load     = accept & inwin;
  end

  // Request queue next state
  always_comb begin
    qy_d      = qy_q;
    qx_d      = qx_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    cfg_err_d = cfg_fire & ~cfg_ok;
    if (push) begin
      qy_d[wr_ptr_q] = cfg_y;
      qx_d[wr_ptr_q] = cfg_x;
      wr_ptr_d       = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(REQ_DEPTH));
  end

  // Frame FSM and raster counters
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    y0_d    = y0_q;
    x0_d    = x0_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          y0_d    = qy_q[rd_ptr_q];
          x0_d    = qx_q[rd_ptr_q];
          row_d   = '0;
          col_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = S_IDLE;
            end else begin
              row_d = row_q + YW'(1);
            end
          end else begin
            col_d = col_q + XW'(1);
          end
        end
      end
    endcase
  end

  // Output register runs independently of the FSM so it can drain across frames
  always_comb begin
    out_valid_d = load | (out_valid_q & ~out_ready);
    pixel_out_d = load ? pixel_in : pixel_out_q;
    if (load) begin
      out_last_d = win_last;
    end else if (out_valid_q & ~out_ready) begin
      out_last_d = out_last_q;
    end else begin
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      y0_q        <= '0;
      x0_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pixel_out_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      cfg_err_q   <= cfg_err_d;
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      y0_q        <= y0_d;
      x0_q        <= x0_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pixel_out_q <= pixel_out_d;
    end
  end

  // Queue payload needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    qy_q <= qy_d;
    qx_q <= qx_d;
  end

`ifdef CROP_SEQ_STATS_EN
  logic [31:0] frame_count_q, frame_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  always_comb begin
    frame_count_d = frame_count_q + 32'(accept & last_row & last_col);
    drop_count_d  = drop_count_q + 32'(accept & ~inwin);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
`endif

  assign cfg_ready = ~full_q;
  assign cfg_err   = cfg_err_q;
  assign pixel_out = pixel_out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == S_STREAM);

endmodule

// File: tb/tb_crop_frame_sequencer.sv
// Directed bench for crop_frame_sequencer with 40x40 frames and a 20x20 window.
module tb_crop_frame_sequencer;

  logic        clk, reset;
  logic        cfg_valid, cfg_ready, cfg_err;
  logic [5:0]  cfg_y, cfg_x;
  logic [11:0] pixel_in, pixel_out;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
`ifdef CROP_SEQ_STATS_EN
  logic [31:0] frame_count, drop_count;
`endif

  crop_frame_sequencer dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_y(cfg_y), .cfg_x(cfg_x), .cfg_err(cfg_err),
    .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy)
`ifdef CROP_SEQ_STATS_EN
    , .frame_count(frame_count), .drop_count(drop_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass;
  int n_fail;
  int n_checks;
  int got_val[$];
  bit got_last[$];
  int pix_end;
  int cfg_acc_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int y, input int x);
    int n;
    n = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_y = 6'(y);
    cfg_x = 6'(x);
    #1;
    while (!cfg_ready && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("push_ready", 32'(n < 5000), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Feeds index-valued pixels with random valid/ready, collecting delivered outputs
  task automatic run_stream(input int start_pix, input int stop_pix, input bit drain);
    int pix, cyc;
    bit a_in, a_out, a_cfg, clr;
    pix = start_pix;
    cyc = 0;
    clr = 1'b0;
    forever begin
      @(negedge clk);
      if (clr) begin
        cfg_valid = 1'b0;
        clr = 1'b0;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      if (pix >= stop_pix && !(drain && out_valid) && !cfg_valid) break;
      if (cyc >= 20000) break;
      out_ready = ($urandom_range(99) < 70);
      in_valid = (pix < stop_pix) && ($urandom_range(99) < 70);
      pixel_in = 12'(pix % 1600);
      #1;
      a_in = in_valid && in_ready;
      a_out = out_valid && out_ready;
      a_cfg = cfg_valid && cfg_ready;
      if (a_out) begin
        got_val.push_back(int'(pixel_out));
        got_last.push_back(out_last);
      end
      @(posedge clk);
      if (a_in) pix++;
      if (a_cfg) begin
        cfg_acc_pix = pix;
        clr = 1'b1;
      end
      cyc++;
    end
    pix_end = pix;
    chk("stream_within_budget", 32'(cyc < 20000), 32'd1);
  endtask

  task automatic verify_frame(input int y0, input int x0, input int base);
    int e, obs;
    bit lst;
    for (int k = 0; k < 400; k++) begin
      e = (y0 + k / 20) * 40 + x0 + k % 20;
      obs = (base + k < got_val.size()) ? got_val[base + k] : -1;
      lst = (base + k < got_last.size()) ? got_last[base + k] : 1'b0;
      chk($sformatf("out_val[%0d]", base + k), 32'(obs), 32'(e));
      chk($sformatf("out_last[%0d]", base + k), 32'(lst), 32'(k == 399));
    end
  endtask

  int pix, held;
  bit stable, a_in, flag;

  initial begin
    n_pass = 0; n_fail = 0; n_checks = 0;
    reset = 1'b1; cfg_valid = 1'b0; cfg_y = '0; cfg_x = '0;
    in_valid = 1'b0; pixel_in = '0; out_ready = 1'b0;
    cfg_acc_pix = -1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_pixel_out", 32'(pixel_out), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;

    // Single frame at (10,10): STREAM two cycles after the push
    push(10, 10);
    #1;
    chk("a_busy_c1", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    chk("a_busy_c2", 32'(busy), 32'd1);
    got_val.delete(); got_last.delete();
    run_stream(0, 1600, 1'b1);
    chk("a_count", 32'(got_val.size()), 32'd400);
    verify_frame(10, 10, 0);
    chk("a_idle_after", 32'(busy), 32'd0);

    // Back-to-back frames at (0,0) then (20,20)
    push(0, 0);
    push(20, 20);
    got_val.delete(); got_last.delete();
    run_stream(0, 3200, 1'b1);
    chk("b_count", 32'(got_val.size()), 32'd800);
    verify_frame(0, 0, 0);
    verify_frame(20, 20, 400);

    // Out-of-range request is rejected and never starts a frame
    push(21, 5);
    #1;
    chk("c_err_pulse", 32'(cfg_err), 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("c_err_clear", 32'(cfg_err), 32'd0);
    flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      flag = flag | busy | in_ready;
    end
    chk("c_stays_idle", 32'(flag), 32'd0);
    chk("c_cfg_ready", 32'(cfg_ready), 32'd1);
    in_valid = 1'b0;
    push(20, 20);
    #1;
    chk("c_no_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    #1;
    chk("c_busy", 32'(busy), 32'd1);
    got_val.delete(); got_last.delete();
    run_stream(0, 1600, 1'b1);
    chk("c_count", 32'(got_val.size()), 32'd400);
    verify_frame(20, 20, 0);

    // Fill the queue behind an active frame; a held request waits for the frame to end
    push(0, 0);
    push(10, 10);
    push(1, 2);
    push(3, 4);
    push(5, 6);
    #1;
    chk("d_full", 32'(cfg_ready), 32'd0);
    chk("d_busy", 32'(busy), 32'd1);
    cfg_valid = 1'b1; cfg_y = 6'd7; cfg_x = 6'd8;
    got_val.delete(); got_last.delete();
    run_stream(0, 1600, 1'b1);
    chk("d_held_accept_pix", 32'(cfg_acc_pix), 32'd1600);
    chk("d_count", 32'(got_val.size()), 32'd400);
    verify_frame(0, 0, 0);

    // Backpressure on frame (10,10): pixel 410 held, input stalls at 411
    pix = 0; held = -1; stable = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b0;
      pixel_in = 12'(pix % 1600);
      #1;
      a_in = in_valid && in_ready;
      if (out_valid) begin
        if (held < 0) held = int'(pixel_out);
        else if (int'(pixel_out) != held) stable = 1'b0;
      end
      @(posedge clk);
      if (a_in) pix++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("e_accepted", 32'(pix), 32'd411);
    chk("e_out_valid", 32'(out_valid), 32'd1);
    chk("e_pixel_out", 32'(pixel_out), 32'd410);
    chk("e_held_first", 32'(held), 32'd410);
    chk("e_stable", 32'(stable), 32'd1);
    chk("e_in_ready", 32'(in_ready), 32'd0);
    chk("e_out_last", 32'(out_last), 32'd0);
    got_val.delete(); got_last.delete();
    run_stream(411, 800, 1'b0);
    chk("e_resume_first", 32'((got_val.size() > 0) ? got_val[0] : -1), 32'd410);
    chk("e_stop_pix", 32'(pix_end), 32'd800);

    // Reset mid-frame discards everything, including queued requests
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("f_out_valid", 32'(out_valid), 32'd0);
    chk("f_busy", 32'(busy), 32'd0);
    chk("f_pixel_out", 32'(pixel_out), 32'd0);
    reset = 1'b0;
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      flag = flag | busy;
    end
    chk("f_queue_empty", 32'(flag), 32'd0);
    chk("f_cfg_ready", 32'(cfg_ready), 32'd1);
    push(10, 10);
    got_val.delete(); got_last.delete();
    run_stream(0, 1600, 1'b1);
    chk("f_count", 32'(got_val.size()), 32'd400);
    verify_frame(10, 10, 0);
`ifdef CROP_SEQ_STATS_EN
    chk("f_frame_count", frame_count, 32'd1);
    chk("f_drop_count", drop_count, 32'd1200);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
